hazard_ctrl_unit: RTL and testbench

Parametrised hazard controller for the 5-stage SimpleRisc pipeline. Generates EX-stage operand-forwarding selects from MEM and WB, detects load-use hazards in decode, and sequences multi-cycle EX operations (mul/div) with a counter-driven stall FSM. It drives the pipeline-register stall and flush controls.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_unit_fwd_select.sv | 31 +++
 rtl/hazard_ctrl_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the SimpleRisc hazard controller.
// Holds forwarding select encodings and the multi-cycle EX FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LAST = 2'd2
    } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Operand forwarding select for one EX source register (combinational).
// Ports: rs (EX source), rd_m/rd_rw + is_wb_m/is_wb_rw (producers), sel (FWD_*).
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_rw,
    input  logic              is_wb_m,
    input  logic              is_wb_rw,
    output logic [1:0]        sel
);

    logic hit_m;
    logic hit_rw;

    assign hit_m  = is_wb_m  && (rd_m  == rs) && (rd_m  != '0);
    assign hit_rw = is_wb_rw && (rd_rw == rs) && (rd_rw != '0);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        sel = FWD_REG;
        if (hit_m)
            sel = FWD_MEM;
        else if (hit_rw)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: EX forwarding, load-use stall, multi-cycle EX stall FSM.
// Ports: forwarding/decode/EX hazard inputs; forwardA_E/forwardB_E, stall_F/D/E,
// flush_D/E/M, mc_busy; stall_cycles exists only with HAZARD_STALL_CNT_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         isWb_M,
    input  logic                         isWb_RW,
    input  logic [REG_AW-1:0]            RD_M,
    input  logic [REG_AW-1:0]            RD_RW,
    input  logic [REG_AW-1:0]            RD_E,
    input  logic [REG_AW-1:0]            RS1_E,
    input  logic [REG_AW-1:0]            RS2_E,
    input  logic [REG_AW-1:0]            RS1_D,
    input  logic [REG_AW-1:0]            RS2_D,
    input  logic                         useRS1_D,
    input  logic                         useRS2_D,
    input  logic                         isLd_E,
    input  logic                         branch_taken_E,
    input  logic                         mc_start_E,
    input  logic [$clog2(MAX_LAT+1)-1:0] mc_lat_E,
    output logic [1:0]                   forwardA_E,
    output logic [1:0]                   forwardB_E,
    output logic                         stall_F,
    output logic                         stall_D,
    output logic                         stall_E,
    output logic                         flush_D,
    output logic                         flush_E,
    output logic                         flush_M,
    output logic                         mc_busy
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]             stall_cycles
`endif
);

    localparam int LW = $clog2(MAX_LAT + 1);
    localparam int CW = $clog2(MAX_LAT);

    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic [LW-1:0] lat;
    logic          mc_go;
    logic          mc_stall;
    logic          ld_use;
    logic          br;
    mc_state_t     state;
    logic [CW-1:0] cnt;
    logic          busy_q;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs       (RS1_E),
        .rd_m     (RD_M),
        .rd_rw    (RD_RW),
        .is_wb_m  (isWb_M),
        .is_wb_rw (isWb_RW),
        .sel      (sel_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs       (RS2_E),
        .rd_m     (RD_M),
        .rd_rw    (RD_RW),
        .is_wb_m  (isWb_M),
        .is_wb_rw (isWb_RW),
        .sel      (sel_b)
    );

    // Oversized latencies are clamped to the longest supported op.
    assign lat = (mc_lat_E > LW'(MAX_LAT)) ? LW'(MAX_LAT) : mc_lat_E;

    assign mc_go    = (state == IDLE) && mc_start_E && (lat >= LW'(2));
    assign mc_stall = mc_go || (state == BUSY);

    assign ld_use = isLd_E && (RD_E != '0) &&
                    ((useRS1_D && (RS1_D == RD_E)) ||
                     (useRS2_D && (RS2_D == RD_E)));

    // A multi-cycle op still owns EX, so the branch is not yet final.
    assign br = branch_taken_E && !mc_stall;

    // Outputs are gated so reset forces every control low at once.
    assign forwardA_E = rst ? sel_a : FWD_REG;
    assign forwardB_E = rst ? sel_b : FWD_REG;
    assign stall_F    = rst && (mc_stall || (ld_use && !br));
    assign stall_D    = rst && (mc_stall || (ld_use && !br));
    assign stall_E    = rst && mc_stall;
    assign flush_M    = rst && mc_stall;
    assign flush_D    = rst && br;
    assign flush_E    = rst && !mc_stall && (br || ld_use);
    assign mc_busy    = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mc_go) begin
                        busy_q <= 1'b1;
                        if (lat == LW'(2)) begin
                            state <= LAST;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(lat - LW'(2));
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CW'(1))
                        state <= LAST;
                    cnt <= cnt - CW'(1);
                end
                LAST: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (stall_F && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end
`else
    logic cnt_w_unused;
    assign cnt_w_unused = CNT_W[0];
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl_unit;

    localparam int REG_AW  = 4;
    localparam int MAX_LAT = 8;
    localparam int CNT_W   = 32;
    localparam int LW      = $clog2(MAX_LAT + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              isWb_M, isWb_RW;
    logic [REG_AW-1:0] RD_M, RD_RW, RD_E;
    logic [REG_AW-1:0] RS1_E, RS2_E, RS1_D, RS2_D;
    logic              useRS1_D, useRS2_D;
    logic              isLd_E, branch_taken_E, mc_start_E;
    logic [LW-1:0]     mc_lat_E;
    logic [1:0]        forwardA_E, forwardB_E;
    logic              stall_F, stall_D, stall_E;
    logic              flush_D, flush_E, flush_M, mc_busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    // {fwdA, fwdB, stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mc_busy}
    logic [10:0] outs;
    assign outs = {forwardA_E, forwardB_E, stall_F, stall_D, stall_E,
                   flush_D, flush_E, flush_M, mc_busy};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW  (REG_AW),
        .MAX_LAT (MAX_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .isWb_M         (isWb_M),
        .isWb_RW        (isWb_RW),
        .RD_M           (RD_M),
        .RD_RW          (RD_RW),
        .RD_E           (RD_E),
        .RS1_E          (RS1_E),
        .RS2_E          (RS2_E),
        .RS1_D          (RS1_D),
        .RS2_D          (RS2_D),
        .useRS1_D       (useRS1_D),
        .useRS2_D       (useRS2_D),
        .isLd_E         (isLd_E),
        .branch_taken_E (branch_taken_E),
        .mc_start_E     (mc_start_E),
        .mc_lat_E       (mc_lat_E),
        .forwardA_E     (forwardA_E),
        .forwardB_E     (forwardB_E),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .stall_E        (stall_E),
        .flush_D        (flush_D),
        .flush_E        (flush_E),
        .flush_M        (flush_M),
        .mc_busy        (mc_busy)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        isWb_M = 0; isWb_RW = 0;
        RD_M = 0; RD_RW = 0; RD_E = 0;
        RS1_E = 0; RS2_E = 0; RS1_D = 0; RS2_D = 0;
        useRS1_D = 0; useRS2_D = 0;
        isLd_E = 0; branch_taken_E = 0;
        mc_start_E = 0; mc_lat_E = 0;
    endtask

    task automatic set_ld_use();
        isLd_E = 1; RD_E = 5; RS2_D = 5; useRS2_D = 1;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        // Reset with every kind of hazard requested: all outputs low.
        RS1_E = 3; RD_M = 3; isWb_M = 1;
        set_ld_use();
        mc_start_E = 1; mc_lat_E = 4;
        #1 chk("reset_outs", 32'(outs), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clr();
        #1 chk("idle_outs", 32'(outs), 32'h0);

        // Forwarding priority on operand A.
        @(negedge clk);
        RS1_E = 3; RD_M = 3; isWb_M = 1; RD_RW = 3; isWb_RW = 1;
        #1 chk("fwdA_mem", 32'(forwardA_E), 32'h2);
        isWb_M = 0;
        #1 chk("fwdA_wb", 32'(forwardA_E), 32'h1);
        RS1_E = 0; RD_M = 0; RD_RW = 0; isWb_M = 1;
        #1 chk("fwdA_r0", 32'(forwardA_E), 32'h0);
        // Each operand uses its own match.
        RS1_E = 3; RD_RW = 3; RS2_E = 7; RD_M = 7;
        #1 chk("fwd_both", 32'(outs), 32'b01_10_0000000);

        // Load-use.
        @(negedge clk);
        clr();
        set_ld_use();
        #1 chk("ld_use", 32'(outs), 32'b00_00_1100100);
        useRS2_D = 0;
        #1 chk("ld_use_unused", 32'(outs), 32'h0);
        useRS1_D = 1; RS1_D = 0; RD_E = 0;
        #1 chk("ld_use_r0", 32'(outs), 32'h0);

        // Branch beats load-use.
        @(negedge clk);
        clr();
        set_ld_use();
        branch_taken_E = 1;
        #1 chk("br_over_ld", 32'(outs), 32'b00_00_0001100);

        // Multi-cycle L=4, start held throughout.
        @(negedge clk);
        clr();
        mc_start_E = 1; mc_lat_E = 4;
        #1 chk("mc4_c0", 32'(outs), 32'b00_00_1110010);
        @(negedge clk);
        #1 chk("mc4_c1", 32'(outs), 32'b00_00_1110011);
        set_ld_use();
        branch_taken_E = 1;
        #1 chk("mc4_br_ign", 32'(outs), 32'b00_00_1110011);
        @(negedge clk);
        isLd_E = 0; branch_taken_E = 0;
        #1 chk("mc4_c2", 32'(outs), 32'b00_00_1110011);
        @(negedge clk);
        #1 chk("mc4_last", 32'(outs), 32'b00_00_0000001);
        @(negedge clk);
        mc_start_E = 0;
        #1 chk("mc4_idle", 32'(outs), 32'h0);

        // L=2: one stall cycle then LAST.
        @(negedge clk);
        mc_start_E = 1; mc_lat_E = 2;
        #1 chk("mc2_c0", 32'(outs), 32'b00_00_1110010);
        @(negedge clk);
        #1 chk("mc2_last", 32'(outs), 32'b00_00_0000001);
        @(negedge clk);
        mc_start_E = 1; mc_lat_E = 1;
        #1 chk("mc1_nostall", 32'(outs), 32'h0);
        @(negedge clk);
        #1 chk("mc1_still_idle", 32'(outs), 32'h0);
        mc_lat_E = 0;
        #1 chk("mc0_nostall", 32'(outs), 32'h0);

        // L=MAX_LAT+3 is clamped: MAX_LAT-1 stall cycles.
        @(negedge clk);
        mc_lat_E = LW'(MAX_LAT + 3);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            #1 n += int'(stall_E);
            @(negedge clk);
            mc_start_E = 0;
        end
        chk("mc_clamp_cnt", 32'(n), 32'(MAX_LAT - 1));
        #1 chk("mc_clamp_done", 32'(outs), 32'h0);

        // Reset in the middle of BUSY.
        @(negedge clk);
        mc_start_E = 1; mc_lat_E = 8;
        @(negedge clk);
        @(negedge clk);
        RS1_E = 3; RD_M = 3; isWb_M = 1;
        #1 chk("mc8_busy", 32'(outs), 32'b10_00_1110011);
        rst = 1'b0;
        #1 chk("rst_mid_busy", 32'(outs), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
        chk("cnt_rst", 32'(stall_cycles), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        clr();
        mc_start_E = 1; mc_lat_E = 3;
        #1 chk("post_rst_idle", 32'(outs), 32'b00_00_1110010);
        @(negedge clk);
        #1 chk("post_rst_busy", 32'(outs), 32'b00_00_1110011);
        @(negedge clk);
        mc_start_E = 0;
        #1 chk("post_rst_last", 32'(outs), 32'b00_00_0000001);
        @(negedge clk);
        #1 chk("post_rst_done", 32'(outs), 32'h0);

`ifdef HAZARD_STALL_CNT_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_ld_use();
        repeat (5) @(negedge clk);
        clr();
        #1 chk("cnt_five", 32'(stall_cycles), 32'd5);
        rst = 1'b0;
        #1 chk("cnt_clear", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
